// File: rtl/sram_word_ctrl.sv
// rtl/sram_word_ctrl.sv - 32-bit word requests split into half-word async SRAM cycles
module sram_word_ctrl #(
    parameter int ADDR_W   = 18,
    parameter int WAIT_CYC = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    output logic              o_ready,
    input  logic              i_we,
    input  logic [31:0]       i_addr,
    input  logic [3:0]        i_bmask,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic              o_ack,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_sram_addr,
    inout  wire  [15:0]       io_sram_dq,
    output logic              o_sram_ce_n,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_lb_n,
    output logic              o_sram_ub_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, ACK} state_t;

    localparam logic [2:0] LAST      = 3'(WAIT_CYC);
    localparam logic [2:0] STRB_LAST = 3'(WAIT_CYC - 1);

    state_t             state, nx_state;
    logic [2:0]         cnt, nx_cnt;
    logic               we_q;
    logic [ADDR_W-2:0]  waddr_q;
    logic [3:0]         bm_q;
    logic [31:0]        wd_q;
    logic               dq_oe;
    logic [15:0]        dq_out;

    logic               accept, oor;
    logic               sel_we;
    logic [ADDR_W-2:0]  sel_waddr;
    logic [3:0]         sel_bm;
    logic [31:0]        sel_wd;
    logic               phase_nx, strobe_nx, hi_nx, lane_lo_nx, lane_hi_nx;
    logic               sample;
    logic [1:0]         rd_mask;
    logic [15:0]        rd_half;
    logic               unused_addr;

    assign unused_addr = ^i_addr[1:0];
    assign o_ready     = (state == IDLE);
    assign accept      = (state == IDLE) && i_req;
    assign oor         = |i_addr[31:ADDR_W+1];
    assign io_sram_dq  = dq_oe ? dq_out : 16'hzzzz;

    // While idle the next phase is set up straight from the request inputs.
    assign sel_we    = (state == IDLE) ? i_we : we_q;
    assign sel_waddr = (state == IDLE) ? i_addr[ADDR_W:2] : waddr_q;
    assign sel_bm    = (state == IDLE) ? i_bmask : bm_q;
    assign sel_wd    = (state == IDLE) ? i_wdata : wd_q;

    always_comb begin
        nx_state = state;
        nx_cnt   = cnt;
        case (state)
            IDLE: begin
                if (i_req) begin
                    nx_cnt = 3'd0;
                    if (oor)                 nx_state = ACK;
                    else if (|i_bmask[1:0])  nx_state = LO;
                    else if (|i_bmask[3:2])  nx_state = HI;
                    else                     nx_state = ACK;
                end
            end
            LO: begin
                if (cnt == LAST) begin
                    nx_cnt   = 3'd0;
                    nx_state = (|bm_q[3:2]) ? HI : ACK;
                end else begin
                    nx_cnt = cnt + 3'd1;
                end
            end
            HI: begin
                if (cnt == LAST) begin
                    nx_cnt   = 3'd0;
                    nx_state = ACK;
                end else begin
                    nx_cnt = cnt + 3'd1;
                end
            end
            default: nx_state = IDLE;
        endcase
    end

    assign phase_nx   = (nx_state == LO) || (nx_state == HI);
    assign strobe_nx  = phase_nx && (nx_cnt < LAST);
    assign hi_nx      = (nx_state == HI);
    assign lane_lo_nx = hi_nx ? sel_bm[2] : sel_bm[0];
    assign lane_hi_nx = hi_nx ? sel_bm[3] : sel_bm[1];

    // Read data is captured on the edge closing the last strobe cycle.
    assign sample  = ((state == LO) || (state == HI)) && !we_q && (cnt == STRB_LAST);
    assign rd_mask = (state == HI) ? bm_q[3:2] : bm_q[1:0];
    assign rd_half = io_sram_dq & {{8{rd_mask[1]}}, {8{rd_mask[0]}}};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            bm_q        <= 4'd0;
            wd_q        <= 32'd0;
            o_rdata     <= 32'd0;
            o_ack       <= 1'b0;
            o_err       <= 1'b0;
            o_sram_addr <= '0;
            o_sram_ce_n <= 1'b1;
            o_sram_we_n <= 1'b1;
            o_sram_oe_n <= 1'b1;
            o_sram_lb_n <= 1'b1;
            o_sram_ub_n <= 1'b1;
            dq_oe       <= 1'b0;
            dq_out      <= 16'd0;
        end else begin
            state <= nx_state;
            cnt   <= nx_cnt;
            o_ack <= (nx_state == ACK);

            if (accept) begin
                we_q    <= i_we;
                waddr_q <= i_addr[ADDR_W:2];
                bm_q    <= i_bmask;
                wd_q    <= i_wdata;
                o_err   <= oor;
                o_rdata <= 32'd0;
            end else begin
                if (state == ACK) o_err <= 1'b0;
                if (sample) begin
                    if (state == HI) o_rdata[31:16] <= rd_half;
                    else             o_rdata[15:0]  <= rd_half;
                end
            end

            // Address and write data stay put through the hold cycle for turnaround.
            o_sram_ce_n <= !phase_nx;
            o_sram_we_n <= !(strobe_nx && sel_we);
            o_sram_oe_n <= !(strobe_nx && !sel_we);
            o_sram_lb_n <= !(strobe_nx && lane_lo_nx);
            o_sram_ub_n <= !(strobe_nx && lane_hi_nx);
            dq_oe       <= phase_nx && sel_we;
            if (phase_nx) begin
                o_sram_addr <= {sel_waddr, hi_nx};
                dq_out      <= hi_nx ? sel_wd[31:16] : sel_wd[15:0];
            end
        end
    end

endmodule

// File: tb/tb_sram_word_ctrl.sv
// tb/tb_sram_word_ctrl.sv - scoreboard bench for sram_word_ctrl at WAIT_CYC 1 and 3
`timescale 1ns/1ps
module tb_sram_word_ctrl;

    localparam int W0 = 1;
    localparam int W1 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]        req, we, ready, ack, err, ce_n, we_n, oe_n, lb_n, ub_n;
    logic [1:0][31:0]  addr, wdata, rdata;
    logic [1:0][3:0]   bm;
    logic [1:0][17:0]  saddr;

    typedef struct {
        int          g;
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
        int          ack_cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          g;
        logic        wr;
        logic [17:0] a;
        logic        lb_n;
        logic        ub_n;
    } ev_t;
    ev_t evq[$];

    logic [7:0] ref_mem [2][0:2047];

    function automatic int wait_of(int g);
        return (g == 0) ? W0 : W1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        wire  [15:0] dq;
        logic [15:0] mem [0:1023];
        int          run;

        sram_word_ctrl #(.ADDR_W(18), .WAIT_CYC((g == 0) ? W0 : W1)) dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_req      (req[g]),
            .o_ready    (ready[g]),
            .i_we       (we[g]),
            .i_addr     (addr[g]),
            .i_bmask    (bm[g]),
            .i_wdata    (wdata[g]),
            .o_rdata    (rdata[g]),
            .o_ack      (ack[g]),
            .o_err      (err[g]),
            .o_sram_addr(saddr[g]),
            .io_sram_dq (dq),
            .o_sram_ce_n(ce_n[g]),
            .o_sram_we_n(we_n[g]),
            .o_sram_oe_n(oe_n[g]),
            .o_sram_lb_n(lb_n[g]),
            .o_sram_ub_n(ub_n[g])
        );

        // Async SRAM device model: drives dq only for an output-enabled read.
        assign dq = (!ce_n[g] && !oe_n[g] && we_n[g]) ? mem[saddr[g][9:0]] : 16'hzzzz;

        initial begin
            for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
            run = 0;
        end

        always @(negedge clk) begin
            if (!ce_n[g] && !we_n[g]) begin
                if (!lb_n[g]) mem[saddr[g][9:0]][7:0]  <= dq[7:0];
                if (!ub_n[g]) mem[saddr[g][9:0]][15:8] <= dq[15:8];
            end
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                run <= 0;
            end else if (!we_n[g] || !oe_n[g]) begin
                if (run == 0) evq.push_back('{g, !we_n[g], saddr[g], lb_n[g], ub_n[g]});
                check("we_oe_exclusive", 32'(we_n[g] | oe_n[g]), 32'd1);
                if (!oe_n[g]) check("read_dq_undisturbed", 32'(dq), 32'(mem[saddr[g][9:0]]));
                run <= run + 1;
            end else if (run > 0) begin
                check("strobe_width", run, wait_of(g));
                check("hold_cycle_ce", 32'(ce_n[g]), 32'd0);
                run <= 0;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst_n && ack[g]) begin
                if (sb.size() == 0 || sb[0].g != g) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ack: inst %0d got ack expected none", g);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_cycle", cyc, e.ack_cyc);
                    check("err", 32'(err[g]), 32'(e.err));
                    if (e.chk_rd) check("rdata", rdata[g], e.rdata);
                end
            end
        end
    end

    task automatic do_req(int g, logic w, logic [31:0] a, logic [3:0] m, logic [31:0] d, bit junk);
        int          n;
        int          c;
        int          nph;
        exp_t        e;
        logic        oor;
        logic [10:0] ba;
        n = 0;
        @(negedge clk);
        while (!ready[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready[g]) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: inst %0d ready 0 expected 1", g);
            return;
        end
        req[g] = 1'b1; we[g] = w; addr[g] = a; bm[g] = m; wdata[g] = d;
        @(posedge clk);
        #1;
        c = cyc;
        req[g]   = junk;
        we[g]    = 1'($urandom);
        addr[g]  = $urandom;
        bm[g]    = 4'($urandom);
        wdata[g] = $urandom;

        oor      = (a[31:19] != 13'd0);
        e.g      = g;
        e.err    = oor;
        e.chk_rd = !w || oor;
        e.rdata  = 32'd0;
        nph      = 0;
        if (!oor) begin
            nph = int'(|m[1:0]) + int'(|m[3:2]);
            for (int b = 0; b < 4; b++) begin
                ba = 11'((a & 32'hFFFF_FFFC) + 32'(b));
                if (w) begin
                    if (m[b]) ref_mem[g][ba] = d[8*b +: 8];
                end else if (m[b]) begin
                    e.rdata[8*b +: 8] = ref_mem[g][ba];
                end
            end
        end
        e.ack_cyc = c + nph * (wait_of(g) + 1);
        sb.push_back(e);
    endtask

    task automatic wait_idle(int g);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready[g]) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: inst %0d ready 0 expected 1", g);
        end
    endtask

    initial begin
        int          n;
        logic        w;
        logic [31:0] a;
        req = '0; we = '0; addr = '0; bm = '0; wdata = '0;
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 2048; i++) ref_mem[g][i] = 8'h00;

        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_ready", 32'(ready[g]), 32'd1);
            check("rst_ack", 32'(ack[g]), 32'd0);
            check("rst_err", 32'(err[g]), 32'd0);
            check("rst_rdata", rdata[g], 32'd0);
            check("rst_sram_addr", 32'(saddr[g]), 32'd0);
            check("rst_strobes", 32'({ce_n[g], we_n[g], oe_n[g], lb_n[g], ub_n[g]}), 32'h1f);
        end
        rst_n = 1'b1;

        // Full-word write then read back
        evq.delete();
        do_req(0, 1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF, 1'b0);
        wait_idle(0);
        check("full_wr_phases", evq.size(), 2);
        if (evq.size() == 2) begin
            for (int i = 0; i < 2; i++) begin
                check("full_wr_addr", 32'(evq[i].a), 32'h80 + 32'(i));
                check("full_wr_kind", 32'({evq[i].wr, evq[i].lb_n, evq[i].ub_n}), 32'b100);
            end
        end
        do_req(0, 1'b0, 32'h100, 4'hF, 32'h0, 1'b0);

        // Single byte lane 2 write: only HI phase
        wait_idle(0);
        evq.delete();
        do_req(0, 1'b1, 32'h104, 4'b0100, 32'h00AA_0000, 1'b0);
        wait_idle(0);
        check("byte_wr_phases", evq.size(), 1);
        if (evq.size() == 1) begin
            check("byte_wr_addr", 32'(evq[0].a), 32'h83);
            check("byte_wr_lanes", 32'({evq[0].wr, evq[0].lb_n, evq[0].ub_n}), 32'b101);
        end
        do_req(0, 1'b0, 32'h104, 4'hF, 32'h0, 1'b0);

        // Low-half-only read
        wait_idle(0);
        evq.delete();
        do_req(0, 1'b0, 32'h200, 4'b0011, 32'h0, 1'b0);
        wait_idle(0);
        check("lo_rd_phases", evq.size(), 1);
        if (evq.size() == 1) check("lo_rd_addr", 32'(evq[0].a), 32'h100);

        // Out-of-range: no SRAM cycles
        evq.delete();
        do_req(0, 1'b0, 32'h0008_0000, 4'hF, 32'h0, 1'b0);
        wait_idle(0);
        check("oor_no_phases", evq.size(), 0);

        // Reset during the HI write strobe
        do_req(0, 1'b1, 32'h300, 4'hF, 32'h1234_5678, 1'b0);
        n = 0;
        while (!(!we_n[0] && saddr[0][0]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hi_strobe_seen", 32'(!we_n[0] && saddr[0][0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_we_n", 32'(we_n[0]), 32'd1);
        check("mid_rst_ce_n", 32'(ce_n[0]), 32'd1);
        check("mid_rst_ready", 32'(ready[0]), 32'd1);
        check("mid_rst_ack", 32'(ack[0]), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_ready", 32'(ready[0]), 32'd1);

        // Randomised traffic, back-to-back, on both wait settings
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 40; i++) begin
                w = 1'($urandom);
                if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0008_0000;
                else a = 32'h400 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
                do_req(g, w, a, 4'($urandom), $urandom, (i != 39) && ($urandom_range(0, 1) == 1));
            end
            req[g] = 1'b0;
            wait_idle(g);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
